// File: rtl/sctrl_pkg.sv
// Shared constants and state encoding for the sensor controller core.
//   DATA_W : sample and read-data width
//   DEPTH  : capture buffer entries (power of two)
//   ADDR_W : log2(DEPTH), width of read index and write pointer
package sctrl_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } sctrl_state_e;

endpackage

// File: rtl/sctrl_buf.sv
// Capture buffer: DEPTH x DATA_W register file with one synchronous write
// port and one asynchronous read port.
//   clk, rst_n      : clock, async active-low reset (zeroes every entry)
//   we, waddr, wdata: write port, takes effect on the rising edge
//   raddr, rdata    : combinational read port
// A read of the entry being written in the same cycle returns the old word.
module sctrl_buf
  import sctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sctrl_core.sv
// Sensor controller core. Requests samples from the sensor while enabled,
// stores one word per accepted transfer, and raises an interrupt once the
// buffer is full until software clears it.
//   ACLK, ARESETn   : clock, async active-low reset
//   sctrl_en        : capture enable (level)
//   sctrl_clear     : clear pointer/interrupt, return to IDLE (pulse or level)
//   sctrl_addr      : buffer read index
//   sctrl_out       : buffer word at sctrl_addr (combinational)
//   sctrl_interrupt : buffer-full interrupt (registered)
//   sensor_ready    : sensor has a valid sample on sensor_out
//   sensor_out      : sensor sample
//   sensor_en       : request to the sensor (combinational)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | not capturing; waits for sctrl_en without sctrl_clear
// FILL  | requesting samples; one word stored per accepted transfer
// FULL  | buffer holds DEPTH words; interrupt high until sctrl_clear
module sctrl_core
  import sctrl_pkg::*;
(
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              sctrl_en,
  input  logic              sctrl_clear,
  input  logic [ADDR_W-1:0] sctrl_addr,
  output logic [DATA_W-1:0] sctrl_out,
  output logic              sctrl_interrupt,
  input  logic              sensor_ready,
  input  logic [DATA_W-1:0] sensor_out,
  output logic              sensor_en
);

  sctrl_state_e      state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic              irq_q, irq_d;
  logic              capture;
  logic              last_slot;

  // Clear gates the request off in the same cycle, so a colliding
  // capture is dropped rather than racing the pointer reset.
  assign sensor_en = (state_q == FILL) && sctrl_en && !sctrl_clear;
  assign capture   = sensor_en && sensor_ready;
  assign last_slot = (wptr_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    if (sctrl_clear) begin
      state_d = IDLE;
      wptr_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sctrl_en) begin
            state_d = FILL;
          end
        end
        FILL: begin
          if (capture) begin
            // Natural wrap leaves wptr at 0 once the buffer is full.
            wptr_d = wptr_q + 1'b1;
            if (last_slot) begin
              state_d = FULL;
            end
          end else if (!sctrl_en) begin
            state_d = IDLE;
          end
        end
        FULL: begin
          state_d = FULL;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    irq_d = (state_d == FULL);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      irq_q   <= irq_d;
    end
  end

  assign sctrl_interrupt = irq_q;

  sctrl_buf u_buf (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .we    (capture),
    .waddr (wptr_q),
    .wdata (sensor_out),
    .raddr (sctrl_addr),
    .rdata (sctrl_out)
  );

endmodule
